// File: rtl/miner_job_ctrl_pkg.sv
// Shared types and constants for the mining job controller.
package miner_ctrl_pkg;

    localparam int MID_W   = 256;
    localparam int DATA_W  = 96;
    localparam int NONCE_W = 32;
    localparam int ID_W    = 8;
    localparam int PER_W   = 34;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        REPORT
    } state_t;

    // Extra nonce periods to let the last nonces drain through the core pipeline.
    function automatic logic [PER_W-1:0] drain_periods(input int loop_log2);
        return PER_W'((1 << (7 - loop_log2)) + 2);
    endfunction

endpackage

// File: rtl/miner_job_ctrl_if.sv
// Host-side job and result channels of the job controller.
interface miner_job_ctrl_if;
    import miner_ctrl_pkg::*;

    logic                 job_valid;
    logic                 job_ready;
    logic [MID_W-1:0]     job_midstate;
    logic [DATA_W-1:0]    job_data;
    logic [NONCE_W-1:0]   job_nonce_min;
    logic [NONCE_W-1:0]   job_nonce_max;
    logic [ID_W-1:0]      job_id;

    logic                 res_valid;
    logic                 res_ready;
    logic                 res_found;
    logic [NONCE_W-1:0]   res_nonce;
    logic [ID_W-1:0]      res_job_id;

    // Host side: offers jobs, consumes results.
    modport master (
        output job_valid, job_midstate, job_data, job_nonce_min, job_nonce_max, job_id,
        output res_ready,
        input  job_ready, res_valid, res_found, res_nonce, res_job_id
    );

    // Controller side.
    modport slave (
        input  job_valid, job_midstate, job_data, job_nonce_min, job_nonce_max, job_id,
        input  res_ready,
        output job_ready, res_valid, res_found, res_nonce, res_job_id
    );

endinterface

// File: rtl/miner_job_ctrl_nonce_range_timer.sv
// Times a nonce range in core periods and masks the post-start pipeline garbage.
module nonce_range_timer
    import miner_ctrl_pkg::*;
#(
    parameter int LOOP_LOG2    = 1,
    parameter int GUARD_CYCLES = 128
) (
    input  logic               hash_clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [NONCE_W-1:0] nonce_min,
    input  logic [NONCE_W-1:0] nonce_max,
    output logic               guard_done,
    output logic               exhausted
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    logic [LOOP_LOG2-1:0] presc;
    logic [PER_W-1:0]     period_cnt;
    logic [GW-1:0]        guard_cnt;
    logic [NONCE_W-1:0]   diff;
    logic [NONCE_W:0]     range;
    logic [PER_W-1:0]     limit;

    // Range is one wider than a nonce so a full 0..FFFFFFFF sweep counts 2^32;
    // limit is another bit wider so adding the drain never overflows.
    assign diff       = nonce_max - nonce_min;
    assign range      = {1'b0, diff} + 33'd1;
    assign limit      = {1'b0, range} + drain_periods(LOOP_LOG2);
    assign exhausted  = (period_cnt == limit);
    assign guard_done = (guard_cnt >= GW'(GUARD_CYCLES));

    // Prescaler divides cycles into nonce periods; guard counter saturates.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            period_cnt <= '0;
            guard_cnt  <= '0;
        end else if (clear) begin
            presc      <= '0;
            period_cnt <= '0;
            guard_cnt  <= '0;
        end else if (enable) begin
            presc <= presc + 1'b1;
            if (&presc)
                period_cnt <= period_cnt + 34'd1;
            if (!guard_done)
                guard_cnt <= guard_cnt + GW'(1);
        end
    end

endmodule

// File: rtl/miner_job_ctrl.sv
// Job controller for one hashing core: load job, start core, time range, report result.
module miner_job_ctrl
    import miner_ctrl_pkg::*;
#(
    parameter int LOOP_LOG2    = 1,
    parameter int GUARD_CYCLES = 128
) (
    input  logic               hash_clk,
    input  logic               reset_n,
    miner_job_ctrl_if.slave    host,
    input  logic               abort,
    output logic [MID_W-1:0]   core_midstate,
    output logic [DATA_W-1:0]  core_work_data,
    output logic [NONCE_W-1:0] core_nonce_min,
    output logic [NONCE_W-1:0] core_nonce_max,
    output logic               core_reset,
    input  logic               core_golden_ticket,
    input  logic [NONCE_W-1:0] core_golden_nonce,
    output logic               busy
);
    state_t             state;
    logic               live;
    logic [ID_W-1:0]    id_q;
    logic               found_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               guard_done;
    logic               exhausted;

    nonce_range_timer #(
        .LOOP_LOG2    (LOOP_LOG2),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .hash_clk   (hash_clk),
        .reset_n    (reset_n),
        .clear      (state == LOAD),
        .enable     (state == RUN),
        .nonce_min  (core_nonce_min),
        .nonce_max  (core_nonce_max),
        .guard_done (guard_done),
        .exhausted  (exhausted)
    );

    // live keeps job_ready low while reset is held even though state sits in IDLE.
    assign host.job_ready  = live && (state == IDLE);
    assign host.res_valid  = (state == REPORT);
    assign host.res_found  = found_q;
    assign host.res_nonce  = nonce_q;
    assign host.res_job_id = id_q;
    assign core_reset      = (state == LOAD);
    assign busy            = (state != IDLE);

    // Main sequencer; abort beats a ticket, a ticket beats exhaustion.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            live           <= 1'b0;
            core_midstate  <= '0;
            core_work_data <= '0;
            core_nonce_min <= '0;
            core_nonce_max <= '0;
            id_q           <= '0;
            found_q        <= 1'b0;
            nonce_q        <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (host.job_valid && live) begin
                        core_midstate  <= host.job_midstate;
                        core_work_data <= host.job_data;
                        core_nonce_min <= host.job_nonce_min;
                        core_nonce_max <= host.job_nonce_max;
                        id_q           <= host.job_id;
                        state          <= LOAD;
                    end
                end
                LOAD: state <= abort ? IDLE : RUN;
                RUN: begin
                    if (abort)
                        state <= IDLE;
                    else if (core_golden_ticket && guard_done)
                        state <= CAPTURE;
                    else if (exhausted) begin
                        found_q <= 1'b0;
                        nonce_q <= '0;
                        state   <= REPORT;
                    end
                end
                CAPTURE: begin
                    if (abort)
                        state <= IDLE;
                    else begin
                        found_q <= 1'b1;
                        nonce_q <= core_golden_nonce;
                        state   <= REPORT;
                    end
                end
                REPORT: if (host.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed bench for miner_job_ctrl plus a standalone check of the range timer.
module tb_miner_job_ctrl;
    import miner_ctrl_pkg::*;

    logic               hash_clk;
    logic               reset_n;
    logic               abort;
    logic [MID_W-1:0]   core_midstate;
    logic [DATA_W-1:0]  core_work_data;
    logic [NONCE_W-1:0] core_nonce_min;
    logic [NONCE_W-1:0] core_nonce_max;
    logic               core_reset;
    logic               core_golden_ticket;
    logic [NONCE_W-1:0] core_golden_nonce;
    logic               busy;

    logic               t_clear, t_en;
    logic [NONCE_W-1:0] t_min, t_max;
    logic               t_guard, t_exh;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    miner_job_ctrl_if host();

    miner_job_ctrl #(.LOOP_LOG2(1), .GUARD_CYCLES(128)) dut (
        .hash_clk           (hash_clk),
        .reset_n            (reset_n),
        .host               (host),
        .abort              (abort),
        .core_midstate      (core_midstate),
        .core_work_data     (core_work_data),
        .core_nonce_min     (core_nonce_min),
        .core_nonce_max     (core_nonce_max),
        .core_reset         (core_reset),
        .core_golden_ticket (core_golden_ticket),
        .core_golden_nonce  (core_golden_nonce),
        .busy               (busy)
    );

    nonce_range_timer #(.LOOP_LOG2(1), .GUARD_CYCLES(128)) u_tmr (
        .hash_clk   (hash_clk),
        .reset_n    (reset_n),
        .clear      (t_clear),
        .enable     (t_en),
        .nonce_min  (t_min),
        .nonce_max  (t_max),
        .guard_done (t_guard),
        .exhausted  (t_exh)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic send_job(input logic [31:0] mn, input logic [31:0] mx, input logic [7:0] id);
        host.job_valid     = 1'b1;
        host.job_nonce_min = mn;
        host.job_nonce_max = mx;
        host.job_id        = id;
        host.job_midstate  = {8{mn ^ 32'hA5A5_0000}};
        host.job_data      = {3{mx}};
        tick();
        host.job_valid = 1'b0;
    endtask

    task automatic wait_res(output int cnt);
        cnt = 0;
        while (host.res_valid !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic take_res();
        host.res_ready = 1'b1;
        tick();
        host.res_ready = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b0;
        abort              = 1'b0;
        core_golden_ticket = 1'b0;
        core_golden_nonce  = '0;
        host.job_valid     = 1'b0;
        host.job_midstate  = '0;
        host.job_data      = '0;
        host.job_nonce_min = '0;
        host.job_nonce_max = '0;
        host.job_id        = '0;
        host.res_ready     = 1'b0;
        t_clear = 1'b0;
        t_en    = 1'b0;
        t_min   = 32'h0;
        t_max   = 32'hFFFF_FFFF;

        // Reset values
        #2;
        chk("rst_job_ready", host.job_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", host.res_valid, 0);
        chk("rst_core_reset", core_reset, 0);
        chk("rst_core_mid", core_midstate[63:0], 0);
        tick();
        chk("rst_job_ready_held", host.job_ready, 0);
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_ready", host.job_ready, 1);

        // Job 1: 0..9 exhausts after 2*(10+66) cycles of RUN
        send_job(32'd0, 32'd9, 8'h11);
        chk("j1_load_core_reset", core_reset, 1);
        chk("j1_busy", busy, 1);
        chk("j1_core_min", core_nonce_min, 0);
        chk("j1_core_max", core_nonce_max, 9);
        chk("j1_core_mid", core_midstate[31:0], 32'hA5A5_0000);
        tick();
        chk("j1_run_core_reset", core_reset, 0);
        wait_res(n);
        chk("j1_latency", n, 153);
        chk("j1_found", host.res_found, 0);
        chk("j1_nonce", host.res_nonce, 0);
        chk("j1_id", host.res_job_id, 8'h11);
        take_res();
        chk("j1_valid_drop", host.res_valid, 0);
        chk("j1_ready_back", host.job_ready, 1);

        // Job 2: ticket 300 cycles into RUN, result stalls 5 cycles
        send_job(32'h100, 32'h10_0000, 8'h22);
        tick();
        repeat (300) tick();
        core_golden_ticket = 1'b1;
        core_golden_nonce  = 32'h0000_ABCD;
        tick();
        core_golden_ticket = 1'b0;
        chk("j2_capture_no_valid", host.res_valid, 0);
        tick();
        core_golden_nonce = 32'hDEAD_0000;
        chk("j2_valid", host.res_valid, 1);
        chk("j2_found", host.res_found, 1);
        chk("j2_nonce", host.res_nonce, 32'h0000_ABCD);
        chk("j2_id", host.res_job_id, 8'h22);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("j2_stall_valid", host.res_valid, 1);
            chk("j2_stall_nonce", host.res_nonce, 32'h0000_ABCD);
        end
        take_res();
        chk("j2_valid_drop", host.res_valid, 0);

        // Job 3: ticket inside guard ignored; single nonce exhausts after 2*67
        send_job(32'h7, 32'h7, 8'h33);
        tick();
        repeat (50) tick();
        core_golden_ticket = 1'b1;
        core_golden_nonce  = 32'h1234_5678;
        tick();
        core_golden_ticket = 1'b0;
        chk("j3_guard_busy", busy, 1);
        wait_res(n);
        chk("j3_latency", n, 84);
        chk("j3_found", host.res_found, 0);
        chk("j3_nonce", host.res_nonce, 0);
        chk("j3_id", host.res_job_id, 8'h33);
        take_res();

        // Job 4: abort in RUN
        send_job(32'h0, 32'h10_0000, 8'h44);
        tick();
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("j4_abort_busy", busy, 0);
        chk("j4_abort_ready", host.job_ready, 1);
        repeat (3) tick();
        chk("j4_abort_no_res", host.res_valid, 0);

        // Job 5: abort coincident with a post-guard ticket
        send_job(32'h0, 32'h10_0000, 8'h45);
        tick();
        repeat (200) tick();
        abort              = 1'b1;
        core_golden_ticket = 1'b1;
        tick();
        abort              = 1'b0;
        core_golden_ticket = 1'b0;
        chk("j5_abort_busy", busy, 0);
        chk("j5_abort_ready", host.job_ready, 1);
        repeat (3) tick();
        chk("j5_abort_no_res", host.res_valid, 0);

        // Job 6: wrap range FFFFFFFE..1 is 4 nonces -> 2*70 cycles
        send_job(32'hFFFF_FFFE, 32'h1, 8'h88);
        tick();
        wait_res(n);
        chk("j6_wrap_latency", n, 141);
        chk("j6_id", host.res_job_id, 8'h88);
        // Reset during REPORT discards the result
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", host.res_valid, 0);
        chk("rst_mid_ready", host.job_ready, 0);
        chk("rst_mid_busy", busy, 0);
        #2 reset_n = 1'b1;
        tick();
        chk("rst_mid_ready_back", host.job_ready, 1);

        // Back-to-back jobs
        send_job(32'h3, 32'h3, 8'h66);
        tick();
        wait_res(n);
        chk("b1_latency", n, 135);
        chk("b1_id", host.res_job_id, 8'h66);
        take_res();
        send_job(32'h5, 32'h6, 8'h77);
        tick();
        wait_res(n);
        chk("b2_latency", n, 137);
        chk("b2_id", host.res_job_id, 8'h77);
        chk("b2_found", host.res_found, 0);
        take_res();
        repeat (20) tick();
        chk("b2_single_result", host.res_valid, 0);
        chk("b2_idle", busy, 0);

        // Timer unit: full 32-bit range, limit = 2^32 + 66
        t_clear = 1'b1;
        tick();
        t_clear = 1'b0;
        chk("tmr_limit", u_tmr.limit, 34'h1_0000_0042);
        chk("tmr_clear_exh", t_exh, 0);
        chk("tmr_clear_guard", t_guard, 0);
        t_en = 1'b1;
        repeat (127) tick();
        chk("tmr_guard_127", t_guard, 0);
        tick();
        chk("tmr_guard_128", t_guard, 1);
        t_en = 1'b0;
        force u_tmr.period_cnt = 34'h1_0000_0041;
        #1;
        chk("tmr_exh_before", t_exh, 0);
        force u_tmr.period_cnt = 34'h1_0000_0042;
        #1;
        chk("tmr_exh_at", t_exh, 1);
        release u_tmr.period_cnt;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
